// File: rtl/nexthop_candidate_scan.sv
// Neighbour table with a sequential scanner that picks the best-Q neighbour
// sitting exactly one hop closer to the cluster head.
module nexthop_candidate_scan #(
    parameter int ID_W  = 8,
    parameter int HOP_W = 8,
    parameter int Q_W   = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [ID_W-1:0]            wr_id,
    input  logic [HOP_W-1:0]           wr_hops,
    input  logic [Q_W-1:0]             wr_qvalue,
    output logic                       wr_drop,
    input  logic                       scan_start,
    input  logic [HOP_W-1:0]           my_hops_ch,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [ID_W-1:0]            best_id,
    output logic [Q_W-1:0]             best_qvalue,
    output logic [$clog2(DEPTH):0]     num_neighbors,
    output logic                       table_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [ID_W-1:0]  tbl_id_q   [DEPTH];
    logic [HOP_W-1:0] tbl_hops_q [DEPTH];
    logic [Q_W-1:0]   tbl_q_q    [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HOP_W-1:0] target_q, target_d;
    logic             nocand_q, nocand_d;
    logic             cand_q, cand_d;
    logic [ID_W-1:0]  cid_q, cid_d;
    logic [Q_W-1:0]   cq_q, cq_d;
    logic             found_q, found_d;
    logic [ID_W-1:0]  best_id_q, best_id_d;
    logic [Q_W-1:0]   best_q_q, best_q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             drop_q, drop_d;

    logic             idle;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_widx;

    logic [ID_W-1:0]  ent_id;
    logic [HOP_W-1:0] ent_hops;
    logic [Q_W-1:0]   ent_q;
    logic             qual;
    logic             take;
    logic             last;
    logic             any;

    assign idle = (state_q == S_IDLE);

    // Only slots below the committed count hold live records.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && (CNT_W'(i) < cnt_q) && (tbl_id_q[i] == wr_id)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign tbl_we   = wr_en && !clear && idle && (hit || !full_q);
    assign tbl_widx = hit ? hit_idx : cnt_q[IDX_W-1:0];

    always_comb begin
        drop_d = wr_en && !clear && (!idle || (full_q && !hit));
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tbl_we && !hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        full_d = (cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_id_q[i]   <= '0;
                tbl_hops_q[i] <= '0;
                tbl_q_q[i]    <= '0;
            end
        end else if (tbl_we) begin
            tbl_id_q[tbl_widx]   <= wr_id;
            tbl_hops_q[tbl_widx] <= wr_hops;
            tbl_q_q[tbl_widx]    <= wr_qvalue;
        end
    end

    assign ent_id   = tbl_id_q[idx_q];
    assign ent_hops = tbl_hops_q[idx_q];
    assign ent_q    = tbl_q_q[idx_q];

    // First qualifier always wins; later ones need a strictly larger Q.
    assign qual = !nocand_q && (ent_hops == target_q);
    assign take = qual && (!cand_q || (ent_q > cq_q));
    assign last = (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));
    assign any  = cand_q || take;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        target_d  = target_q;
        nocand_d  = nocand_q;
        cand_d    = cand_q;
        cid_d     = cid_q;
        cq_d      = cq_q;
        found_d   = found_q;
        best_id_d = best_id_q;
        best_q_d  = best_q_q;
        if (clear) begin
            state_d = S_IDLE;
            found_d = 1'b0;
            cand_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (scan_start) begin
                        target_d = my_hops_ch - HOP_W'(1);
                        nocand_d = (my_hops_ch == '0);
                        cand_d   = 1'b0;
                        cid_d    = '0;
                        cq_d     = '0;
                        idx_d    = '0;
                        if (cnt_q == '0) begin
                            state_d = S_DONE;
                            found_d = 1'b0;
                        end else begin
                            state_d = S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (take) begin
                        cand_d = 1'b1;
                        cid_d  = ent_id;
                        cq_d   = ent_q;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (last) begin
                        state_d = S_DONE;
                        found_d = any;
                        if (any) begin
                            best_id_d = take ? ent_id : cid_q;
                            best_q_d  = take ? ent_q : cq_q;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            target_q  <= '0;
            nocand_q  <= 1'b0;
            cand_q    <= 1'b0;
            cid_q     <= '0;
            cq_q      <= '0;
            found_q   <= 1'b0;
            best_id_q <= '0;
            best_q_q  <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            target_q  <= target_d;
            nocand_q  <= nocand_d;
            cand_q    <= cand_d;
            cid_q     <= cid_d;
            cq_q      <= cq_d;
            found_q   <= found_d;
            best_id_q <= best_id_d;
            best_q_q  <= best_q_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            drop_q    <= drop_d;
        end
    end

    assign busy          = (state_q == S_SCAN) || (state_q == S_DONE);
    assign done          = (state_q == S_DONE);
    assign found         = found_q;
    assign best_id       = best_id_q;
    assign best_qvalue   = best_q_q;
    assign num_neighbors = cnt_q;
    assign table_full    = full_q;
    assign wr_drop       = drop_q;

endmodule

// File: tb/tb_nexthop_candidate_scan.sv
// Scoreboard bench for nexthop_candidate_scan: a reference table model
// predicts each scan result and write drop.
`timescale 1ns/1ps
module tb_nexthop_candidate_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wr_en;
    logic [7:0]  wr_id;
    logic [7:0]  wr_hops;
    logic [15:0] wr_qvalue;
    logic        wr_drop;
    logic        scan_start;
    logic [7:0]  my_hops_ch;
    logic        busy;
    logic        done;
    logic        found;
    logic [7:0]  best_id;
    logic [15:0] best_qvalue;
    logic [4:0]  num_neighbors;
    logic        table_full;

    nexthop_candidate_scan #(
        .ID_W(8), .HOP_W(8), .Q_W(16), .DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_id(wr_id), .wr_hops(wr_hops),
        .wr_qvalue(wr_qvalue), .wr_drop(wr_drop),
        .scan_start(scan_start), .my_hops_ch(my_hops_ch),
        .busy(busy), .done(done), .found(found),
        .best_id(best_id), .best_qvalue(best_qvalue),
        .num_neighbors(num_neighbors), .table_full(table_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          found;
        logic [7:0]  id;
        logic [15:0] q;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;

    int          m_n = 0;
    logic [7:0]  m_id   [16];
    logic [7:0]  m_hops [16];
    logic [15:0] m_q    [16];

    function automatic bit m_write(logic [7:0] id, logic [7:0] h, logic [15:0] q);
        for (int i = 0; i < m_n; i++) begin
            if (m_id[i] == id) begin
                m_hops[i] = h;
                m_q[i] = q;
                return 1'b0;
            end
        end
        if (m_n < 16) begin
            m_id[m_n] = id;
            m_hops[m_n] = h;
            m_q[m_n] = q;
            m_n++;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_best(input logic [7:0] my, output bit f,
                                   output logic [7:0] id, output logic [15:0] q);
        logic [7:0] t;
        f = 1'b0;
        id = '0;
        q = '0;
        if (my == 8'd0) return;
        t = my - 8'd1;
        for (int i = 0; i < m_n; i++) begin
            if (m_hops[i] == t && (!f || m_q[i] > q)) begin
                f = 1'b1;
                id = m_id[i];
                q = m_q[i];
            end
        end
    endfunction

    // Cycles since the accepted scan_start, counting the sampling cycle as 1.
    always @(posedge clk or posedge rst) begin
        if (rst) lat <= 0;
        else if (scan_start && !busy && !clear) lat <= 1;
        else lat <= lat + 1;
    end

    always @(negedge clk) begin
        if (!rst && done) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: done=1 required=no done pending");
            end else begin
                mon_e = sbq.pop_front();
                if (found !== mon_e.found || lat !== mon_e.lat ||
                    (mon_e.found && (best_id !== mon_e.id || best_qvalue !== mon_e.q))) begin
                    miscompares++;
                    $display("FAIL scan_result: found=%0d id=%0d q=%0d lat=%0d required found=%0d id=%0d q=%0d lat=%0d",
                             found, best_id, best_qvalue, lat,
                             mon_e.found, mon_e.id, mon_e.q, mon_e.lat);
                end
            end
        end
    end

    task automatic do_write(input logic [7:0] id, input logic [7:0] h, input logic [15:0] q);
        bit exp_drop;
        exp_drop = m_write(id, h, q);
        wr_en = 1'b1;
        wr_id = id;
        wr_hops = h;
        wr_qvalue = q;
        @(negedge clk);
        wr_en = 1'b0;
        vectors++;
        if (wr_drop !== exp_drop || num_neighbors !== 5'(m_n)) begin
            miscompares++;
            $display("FAIL write_%0d: drop=%0d count=%0d required drop=%0d count=%0d",
                     id, wr_drop, num_neighbors, exp_drop, m_n);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_n = 0;
    endtask

    task automatic start_scan(input logic [7:0] my);
        exp_t e;
        m_best(my, e.found, e.id, e.q);
        e.lat = m_n + 1;
        sbq.push_back(e);
        scan_start = 1'b1;
        my_hops_ch = my;
        @(negedge clk);
        scan_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: done=0 required=1 within 60 cycles", tag);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, done, found, wr_drop, table_full} !== 5'b0 ||
            best_id !== 8'd0 || best_qvalue !== 16'd0 || num_neighbors !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%0d done=%0d found=%0d drop=%0d id=%0d q=%0d n=%0d required all 0",
                     busy, done, found, wr_drop, best_id, best_qvalue, num_neighbors);
        end
    endtask

    task automatic test_basic();
        do_write(8'd3, 8'd2, 16'd500);
        do_write(8'd7, 8'd1, 16'd300);
        do_write(8'd9, 8'd1, 16'd800);
        start_scan(8'd2);
        wait_done("basic");
        vectors++;
        if (found !== 1'b1 || best_id !== 8'd9 || best_qvalue !== 16'd800) begin
            miscompares++;
            $display("FAIL basic_best: found=%0d id=%0d q=%0d required 1 9 800",
                     found, best_id, best_qvalue);
        end
    endtask

    task automatic test_ties();
        do_clear();
        do_write(8'd5, 8'd1, 16'd400);
        do_write(8'd6, 8'd1, 16'd400);
        start_scan(8'd2);
        wait_done("tie");
        vectors++;
        if (best_id !== 8'd5) begin
            miscompares++;
            $display("FAIL tie_lower_idx: id=%0d required 5", best_id);
        end
        do_write(8'd6, 8'd1, 16'd401);
        vectors++;
        if (num_neighbors !== 5'd2) begin
            miscompares++;
            $display("FAIL update_count: n=%0d required 2", num_neighbors);
        end
        start_scan(8'd2);
        wait_done("update");
        vectors++;
        if (best_id !== 8'd6 || best_qvalue !== 16'd401) begin
            miscompares++;
            $display("FAIL update_best: id=%0d q=%0d required 6 401", best_id, best_qvalue);
        end
    endtask

    task automatic test_qedges();
        do_clear();
        do_write(8'd20, 8'd3, 16'd0);
        do_write(8'd21, 8'd4, 16'd50);
        start_scan(8'd4);
        wait_done("zero_q");
        vectors++;
        if (found !== 1'b1 || best_id !== 8'd20 || best_qvalue !== 16'd0) begin
            miscompares++;
            $display("FAIL zero_q_taken: found=%0d id=%0d q=%0d required 1 20 0",
                     found, best_id, best_qvalue);
        end
        do_write(8'd22, 8'd3, 16'h7fff);
        do_write(8'd23, 8'd3, 16'h8000);
        do_write(8'd24, 8'd3, 16'hffff);
        do_write(8'd25, 8'd3, 16'hfffe);
        start_scan(8'd4);
        wait_done("unsigned");
    endtask

    task automatic test_nocand();
        start_scan(8'd0);
        wait_done("hops0");
        vectors++;
        if (found !== 1'b0) begin
            miscompares++;
            $display("FAIL hops0_found: found=%0d required 0", found);
        end
        start_scan(8'd9);
        wait_done("no_target");
        vectors++;
        if (found !== 1'b0) begin
            miscompares++;
            $display("FAIL no_target_found: found=%0d required 0", found);
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 16; i++) begin
            do_write(8'(100 + i), 8'(i % 3), 16'($urandom_range(0, 9000)));
        end
        vectors++;
        if (table_full !== 1'b1 || num_neighbors !== 5'd16) begin
            miscompares++;
            $display("FAIL full_flag: full=%0d n=%0d required 1 16", table_full, num_neighbors);
        end
        do_write(8'd200, 8'd1, 16'd1);
        vectors++;
        if (wr_drop !== 1'b1 || num_neighbors !== 5'd16) begin
            miscompares++;
            $display("FAIL full_drop: drop=%0d n=%0d required 1 16", wr_drop, num_neighbors);
        end
        do_write(8'd105, 8'd1, 16'd9999);
        vectors++;
        if (wr_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL full_update: drop=%0d required 0", wr_drop);
        end
        start_scan(8'd2);
        wait_done("full");
        vectors++;
        if (best_id !== 8'd105 || best_qvalue !== 16'd9999) begin
            miscompares++;
            $display("FAIL full_best: id=%0d q=%0d required 105 9999", best_id, best_qvalue);
        end
    endtask

    task automatic test_midscan_write();
        do_clear();
        do_write(8'd3, 8'd2, 16'd500);
        do_write(8'd7, 8'd1, 16'd300);
        do_write(8'd9, 8'd1, 16'd800);
        start_scan(8'd2);
        wr_en = 1'b1;
        wr_id = 8'd50;
        wr_hops = 8'd1;
        wr_qvalue = 16'hffff;
        @(negedge clk);
        wr_en = 1'b0;
        vectors++;
        if (wr_drop !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_drop: drop=%0d required 1", wr_drop);
        end
        wait_done("midscan_write");
        vectors++;
        if (num_neighbors !== 5'd3 || best_id !== 8'd9) begin
            miscompares++;
            $display("FAIL frozen_table: n=%0d id=%0d required 3 9", num_neighbors, best_id);
        end
    endtask

    task automatic test_midscan_clear();
        int seen = 0;
        start_scan(8'd2);
        void'(sbq.pop_back());
        do_clear();
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen != 0 || busy !== 1'b0 || num_neighbors !== 5'd0 || found !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_abort: dones=%0d busy=%0d n=%0d found=%0d required 0 0 0 0",
                     seen, busy, num_neighbors, found);
        end
    endtask

    task automatic test_clear_write();
        do_write(8'd1, 8'd1, 16'd10);
        do_write(8'd2, 8'd1, 16'd20);
        clear = 1'b1;
        wr_en = 1'b1;
        wr_id = 8'd77;
        wr_hops = 8'd1;
        wr_qvalue = 16'd77;
        @(negedge clk);
        clear = 1'b0;
        wr_en = 1'b0;
        m_n = 0;
        vectors++;
        if (num_neighbors !== 5'd0 || wr_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_wins: n=%0d drop=%0d required 0 0", num_neighbors, wr_drop);
        end
        start_scan(8'd2);
        wait_done("empty");
    endtask

    task automatic test_back_to_back();
        do_write(8'd11, 8'd2, 16'd5);
        do_write(8'd12, 8'd2, 16'd6);
        start_scan(8'd3);
        scan_start = 1'b1;
        my_hops_ch = 8'd1;
        @(negedge clk);
        scan_start = 1'b0;
        wait_done("b2b_first");
        start_scan(8'd3);
        wait_done("b2b_second");
        vectors++;
        if (best_id !== 8'd12) begin
            miscompares++;
            $display("FAIL b2b_best: id=%0d required 12", best_id);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 5; k++) begin
                do_write(8'($urandom_range(0, 19)), 8'($urandom_range(0, 3)),
                         16'($urandom));
            end
            start_scan(8'($urandom_range(0, 4)));
            wait_done("random");
        end
    endtask

    task automatic test_reset_midscan();
        do_clear();
        do_write(8'd3, 8'd2, 16'd500);
        do_write(8'd7, 8'd1, 16'd300);
        do_write(8'd9, 8'd1, 16'd800);
        start_scan(8'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sbq.delete();
        vectors++;
        if ({busy, done, found, wr_drop, table_full} !== 5'b0 ||
            best_id !== 8'd0 || best_qvalue !== 16'd0 || num_neighbors !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_midscan: busy=%0d done=%0d found=%0d id=%0d q=%0d n=%0d required all 0",
                     busy, done, found, best_id, best_qvalue, num_neighbors);
        end
        m_n = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_scan(8'd2);
        vectors++;
        if (done !== 1'b1 || found !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_after_reset: done=%0d found=%0d required 1 0", done, found);
        end
        wait_done("after_reset");
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        wr_en = 1'b0;
        wr_id = '0;
        wr_hops = '0;
        wr_qvalue = '0;
        scan_start = 1'b0;
        my_hops_ch = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_ties();
        test_qedges();
        test_nocand();
        test_full();
        test_midscan_write();
        test_midscan_clear();
        test_clear_write();
        test_back_to_back();
        test_random();
        test_reset_midscan();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results: left=%0d required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
